// File: rtl/fdiv_iter.sv
// fdiv_iter: multi-cycle binary32 divider (RNE rounding, denormals flush to zero).
// Restoring division produces BITS_PER_CYCLE quotient bits per ITER cycle;
// every operand pair, special cases included, takes the same number of cycles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// s_idle  | waiting for operands, in_ready=1
// s_prep  | unpack operands, classify specials, seed the divider
// s_iter  | restoring division, BITS_PER_CYCLE quotient bits per cycle
// s_round | normalise, round to nearest even, range check, load outputs
// s_done  | result presented (out_valid=1) until out_ready

module fdiv_iter #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op1,
  input  logic [31:0]      op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int         ITER    = 26 / BITS_PER_CYCLE;
  localparam logic [4:0] ITER_M1 = 5'(ITER - 1);

  typedef enum logic [2:0] {
    s_idle,
    s_prep,
    s_iter,
    s_round,
    s_done
  } state_t;

  state_t state, state_nx;

  // operands and tag as captured at accept
  logic [31:0]      a_q, b_q;
  logic [TAG_W-1:0] tag_q;

  // unpacked working values
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       m2_q;
  logic [25:0]       rem_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;
  logic              sp_nan_q, sp_dz_q, sp_zero_q;

  // registered outputs
  logic [31:0]      result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [3:0]       flags_q;

  // unpack terms used in s_prep
  logic        z1, z2, nan_in;
  logic [23:0] m1_ld, m2_ld;
  logic [9:0]  exp_ld;

  // divider step results
  logic [25:0] rem_nx, quo_nx;

  // rounding terms used in s_round
  logic [23:0]       mant;
  logic              g_bit, st_bit, inc;
  logic [24:0]       mant_r;
  logic signed [9:0] e_adj, e_fin;
  logic [31:0]       res_rnd;
  logic [3:0]        flg_rnd;
  logic [31:0]       res_fin;
  logic [3:0]        flg_fin;

  // state register; reset aborts any divide in flight
  always_ff @(posedge clk) begin
    if (reset) state <= s_idle;
    else       state <= state_nx;
  end

  // next-state logic; the ITER phase ends when the down-counter hits zero
  always_comb begin
    state_nx = state;
    case (state)
      s_idle:  if (in_valid)       state_nx = s_prep;
      s_prep:                      state_nx = s_iter;
      s_iter:  if (cnt_q == 5'd0)  state_nx = s_round;
      s_round:                     state_nx = s_done;
      s_done:  if (out_ready)      state_nx = s_idle;
      default:                     state_nx = s_idle;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == s_idle);
    out_valid = (state == s_done);
  end

  // operand unpack and special-case classification
  always_comb begin
    z1     = (a_q[30:23] == 8'd0);
    z2     = (b_q[30:23] == 8'd0);
    nan_in = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF) || (z1 && z2);
    m1_ld  = {1'b1, a_q[22:0]};
    m2_ld  = {1'b1, b_q[22:0]};
    exp_ld = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'd127;
  end

  // restoring division: compare, conditionally subtract, shift, per quotient bit.
  // The remainder stays below 2*m2 so 26 bits never overflow.
  always_comb begin
    rem_nx = rem_q;
    quo_nx = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_nx >= {2'b00, m2_q}) begin
        rem_nx = rem_nx - {2'b00, m2_q};
        quo_nx = {quo_nx[24:0], 1'b1};
      end else begin
        quo_nx = {quo_nx[24:0], 1'b0};
      end
      rem_nx = {rem_nx[24:0], 1'b0};
    end
  end

  // normalise to 24 bits, round to nearest even, then range-check the exponent
  always_comb begin
    if (quo_q[25]) begin
      mant   = quo_q[25:2];
      g_bit  = quo_q[1];
      st_bit = quo_q[0] | (rem_q != 26'd0);
      e_adj  = exp_q;
    end else begin
      mant   = quo_q[24:1];
      g_bit  = quo_q[0];
      st_bit = (rem_q != 26'd0);
      e_adj  = exp_q - 10'sd1;
    end
    inc    = g_bit & (st_bit | mant[0]);
    mant_r = {1'b0, mant} + {24'd0, inc};
    // a carry out of the mantissa leaves 1.000..., so the fraction field is zero
    e_fin  = e_adj + $signed({9'd0, mant_r[24]});
    if (e_fin >= 10'sd255) begin
      res_rnd = {sign_q, 8'hFF, 23'd0};
      flg_rnd = 4'b0010;
    end else if (e_fin <= 10'sd0) begin
      res_rnd = {sign_q, 31'd0};
      flg_rnd = 4'b0001;
    end else begin
      res_rnd = {sign_q, e_fin[7:0], mant_r[22:0]};
      flg_rnd = 4'b0000;
    end
  end

  // special cases override the arithmetic result in priority order
  always_comb begin
    if (sp_nan_q) begin
      res_fin = 32'h7FC00000;
      flg_fin = 4'b1000;
    end else if (sp_dz_q) begin
      res_fin = {sign_q, 8'hFF, 23'd0};
      flg_fin = 4'b0100;
    end else if (sp_zero_q) begin
      res_fin = {sign_q, 31'd0};
      flg_fin = 4'b0000;
    end else begin
      res_fin = res_rnd;
      flg_fin = flg_rnd;
    end
  end

  // datapath registers, advanced by state
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      m2_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      sp_nan_q  <= 1'b0;
      sp_dz_q   <= 1'b0;
      sp_zero_q <= 1'b0;
      result_q  <= '0;
      out_tag_q <= '0;
      flags_q   <= '0;
    end else begin
      case (state)
        s_idle: begin
          if (in_valid) begin
            a_q   <= op1;
            b_q   <= op2;
            tag_q <= in_tag;
          end
        end
        s_prep: begin
          sign_q    <= a_q[31] ^ b_q[31];
          exp_q     <= $signed(exp_ld);
          m2_q      <= m2_ld;
          rem_q     <= {2'b00, m1_ld};
          quo_q     <= '0;
          cnt_q     <= ITER_M1;
          sp_nan_q  <= nan_in;
          sp_dz_q   <= z2;
          sp_zero_q <= z1;
        end
        s_iter: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 5'd1;
        end
        s_round: begin
          result_q  <= res_fin;
          flags_q   <= flg_fin;
          out_tag_q <= tag_q;
        end
        default: ;
      endcase
    end
  end

  // outputs only change in s_round, so they are frozen throughout s_done
  always_comb begin
    result    = result_q;
    out_tag   = out_tag_q;
    out_flags = flags_q;
  end

endmodule
